// File: rtl/pipeline_pkg.sv
// Shared state encoding, M-extension funct3 opcodes and opcode helpers
// for the iterative multiply/divide unit.
package pipeline_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

   localparam logic [2:0] MUL    = 3'b000;
   localparam logic [2:0] MULH   = 3'b001;
   localparam logic [2:0] MULHSU = 3'b010;
   localparam logic [2:0] MULHU  = 3'b011;
   localparam logic [2:0] DIV    = 3'b100;
   localparam logic [2:0] DIVU   = 3'b101;
   localparam logic [2:0] REM    = 3'b110;
   localparam logic [2:0] REMU   = 3'b111;

   function automatic logic is_div_op(input logic [2:0] f);
      return (f == DIV) || (f == DIVU) || (f == REM) || (f == REMU);
   endfunction

   function automatic logic is_rem_op(input logic [2:0] f);
      return (f == REM) || (f == REMU);
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; with negate tied to the sign bit it
// yields the absolute value.
module muldiv_sign_fix #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] value,
   input  logic             negate,
   output logic [WIDTH-1:0] fixed
);

   assign fixed = negate ? ((~value) + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit, one radix-2 step per cycle.
// Define MULDIV_WORD_OPS_EN to support the RV64 W-variants selected by is_word_op.
module muldiv_unit
   import pipeline_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic            is_word_op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   muldiv_state_t   state_q, state_d;
   logic [5:0]      count_q, count_d;
   logic [2:0]      op_q, op_d;
   logic            word_q, word_d;
   logic            neg_q, neg_d;
   logic            special_q, special_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] opnd_q, opnd_d;

   logic            word_sel;
   logic [2:0]      op_sel;
   logic            a_signed, b_signed, a_neg, b_neg, result_neg;
   logic            div_zero, div_ovf, special;
   logic [XLEN-1:0] a_ext, b_ext, a_res, mag_a, mag_b, special_val;

   logic [XLEN:0]   mul_sum, div_shift;
   logic [XLEN-1:0] div_diff;
   logic            div_ge;

   logic            mulh_op;
   logic [XLEN-1:0] fix_in, fix_out, final_val;
   logic            fix_neg;
   logic [31:0]     word_val;

`ifdef MULDIV_WORD_OPS_EN
   assign word_sel = is_word_op;
`else
   logic unused_is_word_op;
   assign unused_is_word_op = is_word_op;
   assign word_sel = 1'b0;
`endif

   // Word multiplies only need the low product half, so they all collapse to MUL.
   always_comb begin
      op_sel = funct3;
      if (word_sel && !is_div_op(funct3)) begin
         op_sel = MUL;
      end
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (op_sel)
         MULH, DIV, REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         MULHSU:  a_signed = 1'b1;
         default: a_signed = 1'b0;
      endcase
      a_ext = a;
      b_ext = b;
      a_res = a;
      if (word_sel) begin
         a_res = XLEN'($signed(a[31:0]));
         a_ext = XLEN'(a[31:0]);
         b_ext = XLEN'(b[31:0]);
         if (a_signed) a_ext = XLEN'($signed(a[31:0]));
         if (b_signed) b_ext = XLEN'($signed(b[31:0]));
      end
      a_neg = a_signed && a_ext[XLEN-1];
      b_neg = b_signed && b_ext[XLEN-1];
      case (op_sel)
         MULH, DIV:   result_neg = a_neg ^ b_neg;
         MULHSU, REM: result_neg = a_neg;
         default:     result_neg = 1'b0;
      endcase
      if (word_sel) begin
         div_zero = (b[31:0] == 32'd0);
         div_ovf  = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
      end else begin
         div_zero = (b == '0);
         div_ovf  = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
      end
      div_ovf = div_ovf && a_signed;
      special = is_div_op(op_sel) && (div_zero || div_ovf);
      if (div_zero) begin
         special_val = is_rem_op(op_sel) ? a_res : '1;
      end else begin
         special_val = is_rem_op(op_sel) ? '0 : a_res;
      end
   end

   muldiv_sign_fix #(.WIDTH(XLEN)) u_abs_a (.value(a_ext), .negate(a_neg), .fixed(mag_a));
   muldiv_sign_fix #(.WIDTH(XLEN)) u_abs_b (.value(b_ext), .negate(b_neg), .fixed(mag_b));

   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
   assign div_shift = {hi_q, lo_q[XLEN-1]};
   assign div_ge    = div_shift >= {1'b0, opnd_q};
   assign div_diff  = div_shift[XLEN-1:0] - opnd_q;

   // Divide keeps {remainder, dividend/quotient} in {hi, lo}; multiply keeps
   // {partial product, multiplier} there. Word divides pre-shift the dividend
   // so only 32 steps are needed.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      op_d      = op_q;
      word_d    = word_q;
      neg_d     = neg_q;
      special_d = special_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      opnd_d    = opnd_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d      = op_sel;
               word_d    = word_sel;
               neg_d     = result_neg;
               special_d = special;
               count_d   = word_sel ? 6'd31 : 6'(XLEN-1);
               hi_d      = '0;
               if (special) begin
                  lo_d    = special_val;
                  state_d = DONE;
               end else begin
                  state_d = BUSY;
                  if (is_div_op(op_sel)) begin
                     lo_d   = word_sel ? (mag_a << (XLEN-32)) : mag_a;
                     opnd_d = mag_b;
                  end else begin
                     lo_d   = mag_b;
                     opnd_d = mag_a;
                  end
               end
            end
         end
         BUSY: begin
            if (is_div_op(op_q)) begin
               hi_d = div_ge ? div_diff : div_shift[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], div_ge};
            end else begin
               hi_d = mul_sum[XLEN:1];
               lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
            end
            if (count_q == 6'd0) begin
               state_d = DONE;
            end else begin
               count_d = count_q - 6'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         op_q      <= '0;
         word_q    <= 1'b0;
         neg_q     <= 1'b0;
         special_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         opnd_q    <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         op_q      <= op_d;
         word_q    <= word_d;
         neg_q     <= neg_d;
         special_q <= special_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         opnd_q    <= opnd_d;
      end
   end

   // High half of a negated product: ~hi, plus one only when the low half is zero.
   always_comb begin
      mulh_op = (op_q == MULH) || (op_q == MULHSU) || (op_q == MULHU);
      fix_in  = lo_q;
      fix_neg = neg_q;
      if (mulh_op) begin
         fix_in  = hi_q;
         fix_neg = neg_q && (lo_q == '0);
      end else if (is_rem_op(op_q)) begin
         fix_in = hi_q;
      end
   end

   muldiv_sign_fix #(.WIDTH(XLEN)) u_fix_res (.value(fix_in), .negate(fix_neg), .fixed(fix_out));

   always_comb begin
      final_val = fix_out;
      word_val  = fix_out[31:0];
      if (mulh_op && neg_q && (lo_q != '0)) begin
         final_val = ~hi_q;
      end
      if (word_q) begin
         if (op_q == MUL) begin
            word_val = lo_q[XLEN-1 -: 32];
         end
         final_val = XLEN'($signed(word_val));
      end
      if (special_q) begin
         final_val = lo_q;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = (state_q == DONE) ? final_val : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard testbench for muldiv_unit (XLEN=64); word-op expectations follow
// whether MULDIV_WORD_OPS_EN is defined for the build.
module tb_muldiv_unit;
   import pipeline_pkg::*;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic [2:0]      funct3 = 3'b000;
   logic            is_word_op = 1'b0;
   logic [XLEN-1:0] a = '0;
   logic [XLEN-1:0] b = '0;
   logic            flush = 1'b0;
   logic            busy, done;
   logic [XLEN-1:0] result;

   int checks = 0;
   int errors = 0;
   int cycle_cnt = 0;
   int op_id = 0;

   logic [63:0] exp_res_q[$];
   int          exp_lat_q[$];
   int          start_cyc_q[$];
   int          tag_q[$];

   logic [63:0] mon_res;
   int          mon_lat, mon_start, mon_tag;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .funct3     (funct3),
      .is_word_op (is_word_op),
      .a          (a),
      .b          (b),
      .flush      (flush),
      .busy       (busy),
      .done       (done),
      .result     (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: every done strobe is matched against the oldest outstanding request.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_res_q.size() == 0) begin
            checkOutput("spurious_done", 64'(done), 64'd0);
         end else begin
            mon_res   = exp_res_q.pop_front();
            mon_lat   = exp_lat_q.pop_front();
            mon_start = start_cyc_q.pop_front();
            mon_tag   = tag_q.pop_front();
            checkOutput($sformatf("op%0d_result", mon_tag), result, mon_res);
            checkOutput($sformatf("op%0d_latency", mon_tag), 64'(cycle_cnt - mon_start), 64'(mon_lat));
            checkOutput($sformatf("op%0d_busy_at_done", mon_tag), 64'(busy), 64'd1);
         end
      end
   end

   // Called just after a falling edge; issues one op and waits for the monitor to retire it.
   task automatic applyStimulus(input logic [2:0] f3, input logic w, input logic [63:0] av,
                                input logic [63:0] bv, input logic [63:0] er, input int el);
      logic busy_ok;
      int   tag;
      tag = op_id;
      op_id++;
      funct3 = f3;
      is_word_op = w;
      a = av;
      b = bv;
      start = 1'b1;
      exp_res_q.push_back(er);
      exp_lat_q.push_back(el);
      start_cyc_q.push_back(cycle_cnt);
      tag_q.push_back(tag);
      @(negedge clk);
      start = 1'b0;
      busy_ok = 1'b1;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (exp_res_q.size() == 0) break;
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
      end
      checkOutput($sformatf("op%0d_complete", tag), 64'(exp_res_q.size()), 64'd0);
      checkOutput($sformatf("op%0d_busy_throughout", tag), 64'(busy_ok), 64'd1);
      exp_res_q.delete();
      exp_lat_q.delete();
      start_cyc_q.delete();
      tag_q.delete();
      @(negedge clk);
      #1;
      checkOutput($sformatf("op%0d_idle_flags", tag), 64'({busy, done}), 64'd0);
      checkOutput($sformatf("op%0d_idle_result", tag), result, 64'd0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_flags", 64'({busy, done}), 64'd0);
      checkOutput("reset_result", result, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      applyStimulus(MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
      applyStimulus(DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      applyStimulus(REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      applyStimulus(DIVU,   1'b0, 64'h10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      applyStimulus(REMU,   1'b0, 64'h10, 64'd0, 64'h10, 1);
      applyStimulus(DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
      applyStimulus(REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
      applyStimulus(MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65);
      applyStimulus(MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      applyStimulus(MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      applyStimulus(MULH,   1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 65);
      applyStimulus(DIVU,   1'b0, 64'd100, 64'd7, 64'd14, 65);
      applyStimulus(REMU,   1'b0, 64'd100, 64'd7, 64'd2, 65);
      applyStimulus(DIV,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      applyStimulus(REM,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);

`ifdef MULDIV_WORD_OPS_EN
      applyStimulus(DIV,  1'b1, 64'h1_0000_0010, 64'd4, 64'd4, 33);
      applyStimulus(MUL,  1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
      applyStimulus(MULH, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
      applyStimulus(REM,  1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
      applyStimulus(DIVU, 1'b1, 64'h1_0000_0010, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      applyStimulus(REMU, 1'b1, 64'h1_0000_0010, 64'h1_0000_0000, 64'h10, 1);
`else
      applyStimulus(DIV,  1'b1, 64'h1_0000_0010, 64'd4, 64'h4000_0004, 65);
      applyStimulus(MUL,  1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFE, 65);
      applyStimulus(MULH, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'd0, 65);
      applyStimulus(REM,  1'b1, 64'hFFFF_FFF9, 64'd2, 64'd1, 65);
      applyStimulus(DIVU, 1'b1, 64'h1_0000_0010, 64'h1_0000_0000, 64'd1, 65);
      applyStimulus(REMU, 1'b1, 64'h1_0000_0010, 64'h1_0000_0000, 64'h10, 65);
`endif

      // Flush ten cycles into a divide: the aborted op must never strobe done.
      funct3 = DIV;
      is_word_op = 1'b0;
      a = 64'd1000;
      b = 64'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      checkOutput("flush_busy", 64'(busy), 64'd0);
      checkOutput("flush_done", 64'(done), 64'd0);
      applyStimulus(DIV, 1'b0, 64'd1000, 64'd3, 64'd333, 65);

      // Flush and start together in IDLE: the request is dropped.
      funct3 = MUL;
      a = 64'd5;
      b = 64'd5;
      start = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      #1;
      checkOutput("flush_start_busy", 64'(busy), 64'd0);
      @(negedge clk);

      // Reset in the middle of a multiply, with start raised in the same cycle.
      funct3 = MUL;
      a = 64'd9;
      b = 64'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("midreset_busy", 64'(busy), 64'd0);
      checkOutput("midreset_done", 64'(done), 64'd0);
      checkOutput("midreset_result", result, 64'd0);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("post_reset_busy", 64'(busy), 64'd0);
      @(negedge clk);
      applyStimulus(MUL, 1'b0, 64'd9, 64'd9, 64'd81, 65);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, default 64, datapath width (32 or 64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 funct3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 is_word_op  input  1  RV64 W-variant select.
REQ-007 a, b  input  XLEN  operands (rs1, rs2).
REQ-008 flush  input  1  abort in-flight op (driven by the FlushE path).
REQ-009 busy  output  1  high in BUSY and DONE; feeds hazard stall.
REQ-010 done  output  1  one-cycle result-valid strobe.
REQ-011 result  output  XLEN  result, valid only while done=1.

Function
REQ-012 FSM states: IDLE, BUSY, DONE; the unit latches funct3, is_word_op, a and b on start.
REQ-013 IDLE->BUSY on start; IDLE->DONE directly on start for special divide cases (REQ-019, REQ-020).
REQ-014 In BUSY the unit performs one radix-2 iteration per cycle: shift-add for multiply, restoring shift-subtract for divide, on operand magnitudes.
REQ-015 Iteration count is XLEN, or 32 when is_word_op=1; the 6-bit counter decrements to 0, then BUSY->DONE.
REQ-016 Latency: done asserts exactly N+1 cycles after the start edge (N = iteration count); special cases take 1 cycle.
REQ-017 DONE->IDLE unconditionally after one cycle; start is ignored in BUSY and DONE.
REQ-018 Signed ops use magnitudes plus a final sign fixup: quotient sign = sign(a) xor sign(b), remainder sign = sign(a); MULHSU treats a as signed and b as unsigned.
REQ-019 Divide by zero: quotient = all ones; remainder = a.
REQ-020 Signed overflow (a = most negative, b = -1): quotient = a; remainder = 0.
REQ-021 MUL returns the low XLEN bits of the 2*XLEN product; MULH/MULHSU/MULHU return the high XLEN bits.
REQ-022 flush in any state forces IDLE on the next edge; done is not asserted for the aborted op.
REQ-023 Simultaneous flush and start in IDLE: flush wins and the op is not accepted.
REQ-024 busy, done and result are zero in IDLE.

Reset
REQ-025 reset forces IDLE, clears the counter and operand/accumulator registers, and drives busy=0, done=0, result=0 on the next edge, including mid-operation.

Configuration
REQ-026 Macro MULDIV_WORD_OPS_EN defined: W-variants are supported. Operands are the low 32 bits, special cases are evaluated at 32 bits, and result is the 32-bit value sign-extended to XLEN; is_word_op with funct3 001/010/011 behaves as MULW.
REQ-027 Macro MULDIV_WORD_OPS_EN undefined: is_word_op is ignored and all ops are full XLEN; the macro is required-undefined when XLEN=32.

Structure
REQ-028 pipeline_pkg holds the muldiv_state_t enum (IDLE, BUSY, DONE) and the MUL..REMU funct3 localparams.
REQ-029 One combinational sub-module, muldiv_sign_fix (absolute value and conditional negate at XLEN width), is instantiated for operand conditioning and result fixup.

Verification (XLEN=64, macro defined)
REQ-030 MUL a=7, b=-3 -> result 0xFFFFFFFFFFFFFFEB, done 65 cycles after start, busy high throughout.
REQ-031 DIV a=-7, b=2 -> result -3; REM a=-7, b=2 -> result -1; DIVU a=0x10, b=0 -> result 0xFFFFFFFFFFFFFFFF; REMU a=0x10, b=0 -> result 0x10, done 1 cycle after start.
REQ-032 DIV a=0x8000000000000000, b=-1 -> result 0x8000000000000000; REM of the same operands -> result 0.
REQ-033 MULHU a=0xFFFFFFFFFFFFFFFF, b=2 -> result 1; DIVW a=0x100000010, b=4 -> result 4, done 33 cycles after start; MULW a=0x7FFFFFFF, b=2 -> result 0xFFFFFFFFFFFFFFFE.
REQ-034 Flush asserted 10 cycles into a DIV -> busy=0 on the next cycle, no done pulse; a new start on the following cycle completes correctly.
REQ-035 reset asserted mid-MUL -> busy=0, done=0, result=0 after one edge; a start in the same cycle as reset is ignored.
